// File: rtl/toast_mem_arbiter.sv
// toast_mem_arbiter: shares one single-port synchronous RAM (1-cycle read
// latency) between the instruction-fetch port and the data port.
//
// Handshake (both requesters): req is held with stable address/data until gnt
// is seen high in the same cycle; the memory access is issued in that gnt
// cycle; exactly one cycle later the requester sees rvalid together with its
// rdata (for data writes rvalid is an ack and rdata is don't-care). A
// requester may drop req without ever being granted.
//
// Data has priority, except that once MAX_D_BURST data grants have been made
// back-to-back while a fetch is pending, the fetch wins the next cycle.
module toast_mem_arbiter #(
  parameter int unsigned MAX_D_BURST = 4,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [3:0]        d_we_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [1:0]        dbg_owner_o,
  output logic [3:0]        dbg_cnt_o
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_IF   = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_D_BURST);

  owner_e      owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] d_hold_q, if_hold_q;
  logic        d_gnt_c, if_gnt_c;
  logic        burst_full;

  // Byte-lane bits of the requester addresses are not forwarded to the RAM.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr_i[1:0], d_addr_i[1:0]};

  assign burst_full = (cnt_q == MAX_CNT);

  // State register: response owner, burst counter, per-port held read data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_q   <= OWN_NONE;
      cnt_q     <= '0;
      d_hold_q  <= '0;
      if_hold_q <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (owner_q == OWN_D)  d_hold_q  <= mem_rdata_i;
      if (owner_q == OWN_IF) if_hold_q <= mem_rdata_i;
    end
  end

  // Next state: arbitration, owner of next cycle's response, burst count.
  always_comb begin
    d_gnt_c  = 1'b0;
    if_gnt_c = 1'b0;
    owner_d  = OWN_NONE;
    cnt_d    = cnt_q;
    if (!reset_i) begin
      if (d_req_i && !(if_req_i && burst_full)) begin
        d_gnt_c = 1'b1;
        owner_d = OWN_D;
      end else if (if_req_i) begin
        if_gnt_c = 1'b1;
        owner_d  = OWN_IF;
      end
    end
    // Count data grants only while a fetch is waiting behind them.
    if (d_gnt_c && if_req_i) begin
      cnt_d = burst_full ? cnt_q : cnt_q + 4'd1;
    end else if (if_gnt_c || !if_req_i) begin
      cnt_d = '0;
    end
  end

  // Outputs: memory drive from the granted port, responses from the owner.
  always_comb begin
    if_gnt_o    = if_gnt_c;
    d_gnt_o     = d_gnt_c;
    mem_en_o    = d_gnt_c | if_gnt_c;
    mem_addr_o  = '0;
    mem_we_o    = '0;
    mem_wdata_o = '0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;
    if_rdata_o  = '0;
    d_rdata_o   = '0;
    if (d_gnt_c) begin
      mem_addr_o  = {d_addr_i[ADDR_W-1:2], 2'b00};
      mem_we_o    = d_we_i;
      mem_wdata_o = d_wdata_i;
    end else if (if_gnt_c) begin
      mem_addr_o = {if_addr_i[ADDR_W-1:2], 2'b00};
    end
    if (!reset_i) begin
      d_rvalid_o  = (owner_q == OWN_D);
      if_rvalid_o = (owner_q == OWN_IF);
      d_rdata_o   = (owner_q == OWN_D)  ? mem_rdata_i : d_hold_q;
      if_rdata_o  = (owner_q == OWN_IF) ? mem_rdata_i : if_hold_q;
    end
  end

  assign dbg_owner_o = owner_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_toast_mem_arbiter.sv
// Bench for toast_mem_arbiter: RAM responder, arbitration/response reference
// model with expected-response queues, directed scenarios then random traffic.
module tb_toast_mem_arbiter;

  localparam int MAXB = 4;

  logic        clk, reset_i;
  logic        if_req_i, d_req_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i;
  logic [3:0]  d_we_i;
  logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_en_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_we_o;
  logic [1:0]  dbg_owner_o;
  logic [3:0]  dbg_cnt_o;

  toast_mem_arbiter #(.MAX_D_BURST(MAXB), .ADDR_W(32)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_we_i(d_we_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .dbg_owner_o(dbg_owner_o), .dbg_cnt_o(dbg_cnt_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM responder (read returns pre-write word) ----------------
  logic [31:0] ram [0:4095];
  logic [31:0] shadow [0:4095];
  logic [31:0] mem_rdata_q;
  assign mem_rdata_i = mem_rdata_q;

  always @(posedge clk) begin
    if (mem_en_o) begin
      mem_rdata_q <= ram[mem_addr_o[13:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) ram[mem_addr_o[13:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_d_q[$];
  logic        exp_d_w_q[$];
  logic [31:0] exp_if_q[$];
  int          m_cnt, m_owner;         // owner: 0 none, 1 data, 2 fetch
  logic [31:0] m_d_hold, m_if_hold;
  logic [31:0] pend_d, pend_if;
  logic        pend_d_upd, pend_if_upd;
  logic        e_dg, e_ig;
  logic [31:0] last_d, last_if;
  logic        s_if_gnt;
  logic        rec_en;
  int          rec_idx;
  logic [15:0] hist_ig, hist_iv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare everything visible this cycle against the model.
  task automatic check_now();
    logic [31:0] e_addr, e_wdata, e, old;
    logic [3:0]  e_we;
    logic        w;
    s_if_gnt = if_gnt_o;
    if (rec_en) begin
      hist_ig[rec_idx] = if_gnt_o;
      hist_iv[rec_idx] = if_rvalid_o;
      rec_idx++;
    end
    if (reset_i) begin
      e_dg = 1'b0;
      e_ig = 1'b0;
      chk("rst_ctl", {27'd0, d_gnt_o, if_gnt_o, d_rvalid_o, if_rvalid_o, mem_en_o}, 32'd0);
      chk("rst_mem", mem_addr_o | mem_wdata_o | {28'd0, mem_we_o}, 32'd0);
      chk("rst_rdata", d_rdata_o | if_rdata_o, 32'd0);
      return;
    end
    e_dg = d_req_i && !(if_req_i && m_cnt == MAXB);
    e_ig = !e_dg && if_req_i;
    e_addr = e_dg ? (d_addr_i & ~32'h3) : e_ig ? (if_addr_i & ~32'h3) : 32'd0;
    e_we = e_dg ? d_we_i : 4'd0;
    e_wdata = e_dg ? d_wdata_i : 32'd0;
    chk("gnt", {30'd0, d_gnt_o, if_gnt_o}, {30'd0, e_dg, e_ig});
    chk("mem_en", {31'd0, mem_en_o}, {31'd0, e_dg | e_ig});
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_we", {28'd0, mem_we_o}, {28'd0, e_we});
    chk("mem_wdata", mem_wdata_o, e_wdata);
    chk("owner", {30'd0, dbg_owner_o}, 32'(m_owner));
    chk("cnt", {28'd0, dbg_cnt_o}, 32'(m_cnt));
    chk("rvalid", {30'd0, d_rvalid_o, if_rvalid_o}, {30'd0, m_owner == 1, m_owner == 2});
    // data response / hold
    if (m_owner == 1) begin
      chk("d_resp_q", {31'd0, exp_d_q.size() != 0}, 32'd1);
      if (exp_d_q.size() != 0) begin
        e = exp_d_q.pop_front();
        w = exp_d_w_q.pop_front();
        if (!w) begin
          chk("d_rdata", d_rdata_o, e);
          last_d = d_rdata_o;
        end
        pend_d = e;
        pend_d_upd = 1'b1;
      end
    end else begin
      chk("d_hold", d_rdata_o, m_d_hold);
    end
    // fetch response / hold
    if (m_owner == 2) begin
      chk("if_resp_q", {31'd0, exp_if_q.size() != 0}, 32'd1);
      if (exp_if_q.size() != 0) begin
        e = exp_if_q.pop_front();
        chk("if_rdata", if_rdata_o, e);
        last_if = if_rdata_o;
        pend_if = e;
        pend_if_upd = 1'b1;
      end
    end else begin
      chk("if_hold", if_rdata_o, m_if_hold);
    end
    // push expected responses for this cycle's grant
    if (e_dg) begin
      old = shadow[d_addr_i[13:2]];
      exp_d_q.push_back(old);
      exp_d_w_q.push_back(d_we_i != 4'd0);
      for (int b = 0; b < 4; b++)
        if (d_we_i[b]) shadow[d_addr_i[13:2]][8*b +: 8] = d_wdata_i[8*b +: 8];
    end
    if (e_ig) exp_if_q.push_back(shadow[if_addr_i[13:2]]);
  endtask

  // Advance the model across the rising edge.
  task automatic advance();
    if (reset_i) begin
      m_cnt = 0;
      m_owner = 0;
      m_d_hold = '0;
      m_if_hold = '0;
      exp_d_q.delete();
      exp_d_w_q.delete();
      exp_if_q.delete();
    end else begin
      if (pend_d_upd) m_d_hold = pend_d;
      if (pend_if_upd) m_if_hold = pend_if;
      if (e_dg && if_req_i) m_cnt = (m_cnt == MAXB) ? m_cnt : m_cnt + 1;
      else if (e_ig || !if_req_i) m_cnt = 0;
      m_owner = e_dg ? 1 : e_ig ? 2 : 0;
    end
    pend_d_upd = 1'b0;
    pend_if_upd = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_now();
    @(posedge clk);
    advance();
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic [3:0] we, input logic [31:0] wd);
    if_req_i = ir; if_addr_i = ia;
    d_req_i = dr; d_addr_i = da; d_we_i = we; d_wdata_i = wd;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = {16'hA5A5, 4'h0, 12'(i)};
      shadow[i] = {16'hA5A5, 4'h0, 12'(i)};
    end
    mem_rdata_q = '0;
    m_cnt = 0; m_owner = 0; m_d_hold = '0; m_if_hold = '0;
    pend_d = '0; pend_if = '0; pend_d_upd = 1'b0; pend_if_upd = 1'b0;
    e_dg = 1'b0; e_ig = 1'b0; last_d = '0; last_if = '0; s_if_gnt = 1'b0;
    rec_en = 1'b0; rec_idx = 0; hist_ig = '0; hist_iv = '0;

    // Reset with both requests high: everything quiet.
    reset_i = 1'b1;
    drive(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++) cycle();

    // Release with both held: D,D,D,D,IF,D,D,D,D,IF.
    reset_i = 1'b0;
    rec_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d_addr_i = 32'h0000_0300 + 32'(4 * i);
      cycle();
    end
    rec_en = 1'b0;
    chk("starve_gnt", {22'd0, hist_ig[9:0]}, 32'h210);
    chk("starve_rv", {20'd0, hist_iv[11:0]}, 32'h420);
    idle(2);

    // Fetch only, address 0x104 for three cycles.
    drive(1'b1, 32'h0000_0104, 1'b0, 32'd0, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++) cycle();
    idle(1);
    chk("if_word41", last_if, 32'hA5A5_0041);

    // Data half-word write, then read back.
    drive(1'b0, 32'd0, 1'b1, 32'h0000_2002, 4'b0011, 32'hAABB_CCDD);
    cycle();
    drive(1'b0, 32'd0, 1'b1, 32'h0000_2000, 4'b0000, 32'd0);
    cycle();
    idle(1);
    chk("wr_rd_low", {16'd0, last_d[15:0]}, 32'h0000_CCDD);

    // Alternation: fetch dropped after each grant, data continuous.
    for (int i = 0; i < 24; i++) begin
      d_req_i = 1'b1; d_we_i = 4'd0; d_addr_i = 32'h0000_0400 + 32'(4 * i);
      if_addr_i = 32'h0000_0800 + 32'(4 * i);
      cycle();
      if (s_if_gnt) if_req_i = 1'b0;
      else if (i % 7 == 1) if_req_i = 1'b1;
    end
    idle(2);

    // Reset the cycle after a data read grant: response dropped.
    drive(1'b0, 32'd0, 1'b1, 32'h0000_0104, 4'd0, 32'd0);
    cycle();
    reset_i = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0);
    cycle();
    reset_i = 1'b0;
    idle(3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 16'h3FFF)),
            1'($urandom_range(0, 1)), 32'($urandom_range(0, 16'h3FFF)),
            ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0,
            $urandom());
      reset_i = ($urandom_range(0, 49) == 0);
      cycle();
    end
    reset_i = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
